// File: rtl/video_mem_arbiter.sv
// Shares the single video-memory read port among scan, VGC and spare requesters, then
// steers each returned word back to its owner after the fixed memory latency.

module video_mem_arbiter_starve #(
  parameter int LIMIT = 15,
  parameter int CW    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic win,
  output logic starved
);
  logic [CW-1:0] cnt;

  assign starved = req && (cnt == CW'(LIMIT));

  // Waiting ends either by being served or by giving up the request.
  always_ff @(posedge clk or posedge reset)
    if (reset)                  cnt <= '0;
    else if (!req || win)       cnt <= '0;
    else if (cnt != CW'(LIMIT)) cnt <= cnt + CW'(1);
endmodule

module video_mem_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic                          prio0_en_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          mem_rd_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  input  logic [DATA_WIDTH-1:0]         mem_data_i,
  output logic                          busy_o
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_v;
  logic [NUM_REQ-1:0]                   starved;
  logic [NUM_REQ-1:0]                   win_oh;
  logic [IW-1:0]                        win_idx;
  logic [IW-1:0]                        next_ptr;
  logic [IW-1:0]                        rr_ptr;
  logic                                 win_any;
  logic [READ_LATENCY-1:0][NUM_REQ-1:0] tag_pipe;

  assign addr_v = addr_i;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
    video_mem_arbiter_starve #(.LIMIT(STARVE_LIMIT), .CW(CW)) u_starve (
      .clk     (clk),
      .reset   (reset),
      .req     (req_i[k]),
      .win     (win_oh[k]),
      .starved (starved[k])
    );
  end

  // Descending scans so the lowest index / nearest-to-pointer candidate is written last.
  always_comb begin
    int j;
    j       = 0;
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (starved[IW'(k)]) begin
        win_idx = IW'(k);
        win_any = 1'b1;
      end
    if (!win_any && prio0_en_i && req_i[0]) begin
      win_idx = '0;
      win_any = 1'b1;
    end
    if (!win_any)
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        j = int'(rr_ptr) + i;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (req_i[IW'(j)]) begin
          win_idx = IW'(j);
          win_any = 1'b1;
        end
      end
    if (win_any) win_oh[win_idx] = 1'b1;
  end

  assign next_ptr = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gnt_o      <= '0;
      mem_rd_o   <= 1'b0;
      mem_addr_o <= '0;
      rr_ptr     <= '0;
    end else begin
      gnt_o    <= win_oh;
      mem_rd_o <= win_any;
      if (win_any) begin
        mem_addr_o <= addr_v[win_idx];
        rr_ptr     <= next_ptr;
      end
    end

  // Owner tags ride alongside the memory latency; the last stage lines up with mem_data_i.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tag_pipe <= '0;
      rvalid_o <= '0;
      rdata_o  <= '0;
    end else begin
      tag_pipe[0] <= gnt_o;
      for (int s = 1; s < READ_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
      rvalid_o <= tag_pipe[READ_LATENCY-1];
      if (|tag_pipe[READ_LATENCY-1]) rdata_o <= mem_data_i;
    end

  assign busy_o = (|tag_pipe) | mem_rd_o;
endmodule
